// File: rtl/uart_tx_core.sv
// UART frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | driving the start bit (low)
// DATA   | driving shift_reg[0], one bit per period
// PARITY | driving the latched even-parity bit
// STOP   | driving the stop bit (high)
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   parity_bit;
  logic                   bit_last;
  logic                   accept;
  logic                   chain;
  logic                   serial_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;

  assign bit_last = (bit_cnt == CNT_LAST);
  assign accept   = (state == IDLE) && tx_start;
  // A start taken in the tx_done cycle drives the start bit at once and skips one
  // count, so the new start bit abuts the previous stop bit with no idle cycle.
  assign chain    = accept && tx_done;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      serial_out <= serial_nxt;
      tx_busy    <= busy_nxt;
      tx_done    <= done_nxt;
      if (accept) begin
        shift_reg  <= tx_data;
        parity_bit <= ^tx_data;
        bit_idx    <= '0;
        bit_cnt    <= chain ? CNT_ONE : '0;
      end else if (state == IDLE) begin
        bit_idx <= '0;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_last ? '0 : bit_cnt + CNT_ONE;
        if ((state == DATA) && bit_last) begin
          shift_reg <= shift_reg >> 1;
          bit_idx   <= bit_idx + IDX_ONE;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (tx_start) state_nxt = START;
      START:   if (bit_last) state_nxt = DATA;
      DATA:    if (bit_last && (bit_idx == IDX_LAST))
                 state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_last) state_nxt = STOP;
      STOP:    if (bit_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    serial_nxt = 1'b1;
    case (state)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shift_reg[0];
      PARITY:  serial_nxt = parity_bit;
      default: serial_nxt = 1'b1;
    endcase
    if (chain) serial_nxt = 1'b0;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == STOP) && bit_last;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Serial transmitter that is the partner of the team's 8N1 serial receiver: it takes a parallel byte and shifts it out as a UART frame (start bit, LSB-first data, optional parity, stop bit).
- Bit timing comes from an internal bit-period counter and an internal bit-index counter, both run by a small state machine.
- It sits between the host-side write interface and the serial line pin.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period; legal range 2..1023.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 means no parity bit.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
n_rst  input  1  asynchronous active-low reset.
tx_data  input  DATA_BITS  byte to transmit; sampled only when a start is accepted.
tx_start  input  1  request to transmit; accepted only when tx_busy=0.
serial_out  output  1  serial line; idles high; registered.
tx_busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.
tx_done  output  1  one-cycle pulse on the first cycle after the stop bit completes.

Behaviour:
- Reset (n_rst=0, asynchronous, any state):
  - serial_out=1, tx_busy=0, tx_done=0.
  - State=IDLE; both counters cleared; shift register cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- States are IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_EN=0.
- IDLE:
  - serial_out=1, tx_busy=0.
  - If tx_start=1 on a rising edge: latch tx_data into the shift register, compute parity (XOR of the data bits, so total ones is even), go to START, clear the bit-period counter.
  - A tx_start pulse of one cycle is sufficient.
- START: serial_out=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA:
  - serial_out=shift_reg[0] (LSB first) for CLKS_PER_BIT cycles per bit.
  - Shift right at the end of each bit period; increment the bit index.
  - After bit index DATA_BITS-1 completes, go to PARITY (if enabled) or STOP.
- PARITY: serial_out=latched parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE and assert tx_done for that single cycle.
- Bit-period counter:
  - Counts 0..CLKS_PER_BIT-1.
  - On the terminal value it wraps to 0 and advances the state or bit; there is no extra cycle at any wrap.
  - Counter width is clog2(CLKS_PER_BIT).
- Latency:
  - serial_out falls on the first rising edge after the edge that accepted tx_start.
  - Frame length = (2 + DATA_BITS + PARITY_EN) * CLKS_PER_BIT cycles exactly.
- tx_busy is high in START, DATA, PARITY and STOP; it is low in IDLE, including the tx_done cycle.
- Back-to-back frames: tx_start=1 in the tx_done cycle is accepted, so consecutive frames have zero idle bit-time between the stop bit and the next start bit.
- tx_start while tx_busy=1 is ignored (not queued). A change to tx_data during a frame has no effect on the frame in progress.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset then idle: assert n_rst=0 for 2 cycles, release, hold tx_start=0 for 50 cycles -> serial_out=1, tx_busy=0 and tx_done=0 throughout.
2. Single frame with defaults: tx_data=0xA5, pulse tx_start for 1 cycle ->
   - serial_out is low for 10 cycles.
   - Then data bits 1,0,1,0,0,1,0,1 for 10 cycles each.
   - Then high for 10 cycles.
   - tx_busy is high for exactly 100 cycles; tx_done pulses once on cycle 101.
3. Parity build (PARITY_EN=1):
   - tx_data=0x07 -> parity bit=1 and frame = 110 cycles.
   - tx_data=0xA5 -> parity bit=0.
4. Back-to-back: tx_data=0x55 then 0x0F, with the second tx_start asserted in the tx_done cycle -> the second start bit immediately follows the first stop bit with no idle cycle; both bytes decode correctly.
5. Start while busy: assert tx_start with tx_data=0xFF at cycle 40 of a 0x00 frame -> ignored; the frame remains all-zero data, tx_done pulses once, and no second frame is sent.
6. Reset mid-frame: drop n_rst during data bit 3 -> serial_out=1 and tx_busy=0 asynchronously with no tx_done pulse; a new tx_start after release sends a complete, correct frame.
